// File: rtl/sar_adc_pkg.sv
// Shared state encoding and default sizing for the SAR ADC controller.
package sar_adc_pkg;

    localparam int DATA_WIDTH_DEF    = 8;
    localparam int SETTLE_CYCLES_DEF = 4;
    localparam int CNT_W             = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DECIDE = 2'd2
    } state_e;

    function automatic int idx_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/sar_adc_if.sv
// Conversion handshake and comparator/DAC bundle of the SAR ADC controller.
interface sar_adc_if
    import sar_adc_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
);

    logic                  start;
    logic                  cmp;
    logic [DATA_WIDTH-1:0] dac;
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  busy;

    modport master (
        output start,
        output cmp,
        input  dac,
        input  data,
        input  valid,
        input  busy
    );

    modport slave (
        input  start,
        input  cmp,
        output dac,
        output data,
        output valid,
        output busy
    );

endinterface

// File: rtl/sar_adc_ctrl_sync.sv
// Two-flop synchronizer with synchronous active-low clear.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation controller: walks an R2R DAC MSB-first,
// settling each trial code before sampling the synchronized comparator.
module sar_adc_ctrl
    import sar_adc_pkg::*;
#(
    parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
    input  logic      clk,
    input  logic      rst,
    sar_adc_if.slave  bus
);

    localparam int IW = idx_width(DATA_WIDTH);

    localparam logic [CNT_W-1:0] CNT_LOAD =
        CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [IW-1:0] IDX_MSB =
        IW'(DATA_WIDTH - 1);
    localparam logic [DATA_WIDTH-1:0] MSB_CODE =
        {1'b1, {(DATA_WIDTH-1){1'b0}}};

    state_e                state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] dac_q, dac_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] code;
    logic                  cmp_s;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (bus.cmp),
        .q_o (cmp_s)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            dac_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            dac_q   <= dac_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        dac_d   = dac_q;
        data_d  = data_q;
        valid_d = 1'b0;
        code    = dac_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_SETTLE;
                    idx_d   = IDX_MSB;
                    dac_d   = MSB_CODE;
                    cnt_d   = CNT_LOAD;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = ST_DECIDE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DECIDE: begin
                code[idx_q] = cmp_s;
                if (idx_q != '0) begin
                    code[idx_q - IW'(1)] = 1'b1;
                    idx_d   = idx_q - IW'(1);
                    dac_d   = code;
                    cnt_d   = CNT_LOAD;
                    state_d = ST_SETTLE;
                end else begin
                    data_d  = code;
                    valid_d = 1'b1;
                    // A held start chains straight into the next conversion
                    if (bus.start) begin
                        state_d = ST_SETTLE;
                        idx_d   = IDX_MSB;
                        dac_d   = MSB_CODE;
                        cnt_d   = CNT_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                        dac_d   = code;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.dac   = dac_q;
    assign bus.data  = data_q;
    assign bus.valid = valid_q;
    assign bus.busy  = (state_q != ST_IDLE);

endmodule
